// File: rtl/input_fifo.sv
// Router input-port FIFO. Flits are stored in a circular buffer and presented
// first-word-fall-through. Each accepted pop returns one credit upstream on
// the following cycle. A two-state framing monitor watches accepted writes and
// raises a sticky protocol-error flag. Writes that find no free slot are
// dropped and raise a sticky overflow flag.
module input_fifo #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_valid,
    input  logic [DATA_WIDTH-1:0] rx_flit,
    input  logic                  read_en,
    output logic                  credit_out,
    output logic                  empty,
    output logic                  full,
    output logic [DATA_WIDTH-1:0] flit_out,
    output logic [2:0]            flit_id,
    output logic [3:0]            dst_addr,
    output logic                  overflow,
    output logic                  proto_err
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    localparam logic [2:0] ID_HEADER  = 3'b001;
    localparam logic [2:0] ID_PAYLOAD = 3'b010;
    localparam logic [2:0] ID_TAIL    = 3'b100;

    typedef enum logic {
        IDLE = 1'b0,
        BODY = 1'b1
    } frame_state_t;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count;

    logic                  rd_accept;
    logic                  wr_accept;
    logic [2:0]            rx_id;

    frame_state_t          frame_state;
    frame_state_t          frame_state_next;
    logic                  frame_err;

    // Status flags come straight from the registered occupancy count.
    assign empty = (count == '0);
    assign full  = (count == CNT_W'(DEPTH));

    // A pop needs a head flit. A push needs a free slot, or a slot that a
    // same-cycle pop is freeing.
    assign rd_accept = read_en && !empty;
    assign wr_accept = rx_valid && (!full || rd_accept);

    assign rx_id = rx_flit[31:29];

    // Head of queue is visible combinationally (first-word-fall-through).
    assign flit_out = mem[rd_ptr];
    assign flit_id  = flit_out[31:29];
    assign dst_addr = flit_out[11:8];

    // Flit storage: written on every accepted push.
    // NOTE: the storage array has no reset. Its contents are don't-care while
    // the FIFO is empty, and leaving it unreset lets it map onto plain RAM.
    always_ff @(posedge clk) begin
        if (!rst && wr_accept) begin
            mem[wr_ptr] <= rx_flit;
        end
    end

    // Pointers, occupancy count and credit return. Reset overrides any
    // concurrent push or pop.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            credit_out <= 1'b0;
        end else begin
            if (wr_accept) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_accept) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (wr_accept && !rd_accept) begin
                count <= count + 1'b1;
            end else if (rd_accept && !wr_accept) begin
                count <= count - 1'b1;
            end
            credit_out <= rd_accept;
        end
    end

    // Sticky error flags. They clear only on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow  <= 1'b0;
            proto_err <= 1'b0;
        end else begin
            if (rx_valid && !wr_accept) begin
                overflow <= 1'b1;
            end
            if (frame_err) begin
                proto_err <= 1'b1;
            end
        end
    end

    // Framing FSM: state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_state <= IDLE;
        end else begin
            frame_state <= frame_state_next;
        end
    end

    // Framing FSM: next state. Only accepted writes advance it. A HEADER seen
    // mid-packet starts a new packet, so the FSM stays in BODY.
    // NOTE: the default assignment before the case makes every path assign
    // the output, so no latch is inferred.
    always_comb begin
        frame_state_next = frame_state;
        if (wr_accept) begin
            case (frame_state)
                IDLE: if (rx_id == ID_HEADER) frame_state_next = BODY;
                BODY: if (rx_id == ID_TAIL)   frame_state_next = IDLE;
            endcase
        end
    end

    // Framing FSM: error output. It flags any accepted flit that breaks
    // packet framing. The flit itself is still stored.
    always_comb begin
        frame_err = 1'b0;
        if (wr_accept) begin
            case (frame_state)
                IDLE: frame_err = (rx_id != ID_HEADER);
                BODY: frame_err = !((rx_id == ID_PAYLOAD) || (rx_id == ID_TAIL));
            endcase
        end
    end

endmodule

// File: doc/input_fifo.md
INPUT_FIFO -- requirements
Module: input_fifo

Interface
REQ-001 Parameter DATA_WIDTH, default 32: flit width in bits.
REQ-002 Parameter DEPTH, default 4: flit slots, power of two, minimum 2.
REQ-003 clk  input  1  clock; every state element updates on its rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 rx_valid  input  1  upstream link presents a flit this cycle.
REQ-006 rx_flit  input  DATA_WIDTH  incoming flit; [31:29] flit_id, [11:8] destination address, [7:4] source address.
REQ-007 read_en  input  1  downstream pops the head flit.
REQ-008 credit_out  output  1  one-cycle pulse returning one credit upstream.
REQ-009 empty  output  1  FIFO holds no flits; drives the route-computation empty input.
REQ-010 full  output  1  FIFO holds DEPTH flits.
REQ-011 flit_out  output  DATA_WIDTH  head flit, first-word-fall-through.
REQ-012 flit_id  output  3  flit_out[31:29].
REQ-013 dst_addr  output  4  flit_out[11:8]; meaningful only when flit_id is HEADER.
REQ-014 overflow  output  1  sticky: a write was attempted while no slot was available.
REQ-015 proto_err  output  1  sticky: an accepted flit violated packet framing.

Function
REQ-016 Flit identifiers SHALL be HEADER 3'b001, PAYLOAD 3'b010, TAIL 3'b100; all other values are illegal.
REQ-017 Storage SHALL be a circular buffer with wr_ptr and rd_ptr of log2(DEPTH) bits and a count of log2(DEPTH)+1 bits.
REQ-018 A read SHALL be accepted when read_en=1 and empty=0. read_en while empty is ignored and has no side effects.
REQ-019 A write SHALL be accepted when rx_valid=1 and either full=0, or full=1 and a read is accepted in the same cycle.
REQ-020 Accepted write: rx_flit is stored at wr_ptr; wr_ptr increments modulo DEPTH.
REQ-021 Accepted read: rd_ptr increments modulo DEPTH.
REQ-022 Count: +1 on write only, -1 on read only, unchanged on simultaneous write and read.
REQ-023 empty = (count==0); full = (count==DEPTH). Both are derived from registered count.
REQ-024 flit_out, flit_id and dst_addr SHALL reflect the slot at rd_ptr combinationally. A flit written in cycle N appears at the outputs in cycle N+1.
REQ-025 Simultaneous write and read with count==1: the outputs show the new flit in the next cycle, and empty stays 0.
REQ-026 credit_out SHALL be 1 in the cycle after each accepted read and 0 otherwise.
REQ-027 rx_valid=1 with no write accepted SHALL set overflow. The flit is dropped and FIFO state is unchanged.
REQ-028 A framing FSM SHALL track accepted writes with states IDLE and BODY; reset state is IDLE.
REQ-029 In IDLE:
  - HEADER -> BODY.
  - PAYLOAD, TAIL or illegal id -> set proto_err, stay IDLE.
REQ-030 In BODY:
  - PAYLOAD -> stay BODY.
  - TAIL -> IDLE.
  - HEADER -> set proto_err, stay BODY (treated as a new packet).
  - Illegal id -> set proto_err, stay BODY.
REQ-031 Flits that set proto_err SHALL still be stored; only overflow drops flits.
REQ-032 The FSM SHALL ignore rx_valid cycles that are not accepted.

Reset
REQ-033 While rst=1 the following SHALL hold on each rising edge:
  - wr_ptr, rd_ptr, count := 0.
  - FSM := IDLE.
  - overflow, proto_err, credit_out := 0.
  - empty=1, full=0 in the following cycle.
REQ-034 rst SHALL take priority over concurrent rx_valid and read_en. No flit is accepted and no credit is returned in a reset cycle.
REQ-035 Storage contents need not be cleared; flit_out is don't-care while empty=1.
REQ-036 Sticky flags SHALL clear only on rst.

Verification
REQ-037 Reset, then write HEADER dst=4'hA, PAYLOAD, TAIL on consecutive cycles ->
  - empty falls the cycle after the first write.
  - flit_id=3'b001 and dst_addr=4'hA at the head.
  - proto_err=0.
REQ-038 Fill 4 flits, then assert rx_valid with read_en=0 -> full=1, overflow=1, count stays 4, and the head flit is unchanged.
REQ-039 With full=1, assert rx_valid and read_en in the same cycle ->
  - Write accepted; count stays 4.
  - credit_out=1 in the next cycle.
  - overflow stays 0.
REQ-040 With count=1, assert write and read in the same cycle -> empty stays 0 and the new flit appears at the head. Repeat for 9 flits to check pointer wrap.
REQ-041 From IDLE, write PAYLOAD -> proto_err=1 and the flit is stored. Then write HEADER, HEADER -> FSM ends in BODY.
REQ-042 Assert rst mid-packet with count=3 -> empty=1, credit_out=0, flags cleared. The next HEADER is accepted without proto_err.
